// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - register-file write-port arbitration bus: pipeline and aux inputs, write port and hazard outputs.
interface wb_arbiter_if;
  logic        RegWrite;
  logic [4:0]  toAW;
  logic [31:0] wbData;
  logic        auxValid;
  logic [4:0]  auxAddr;
  logic [31:0] auxData;
  logic        auxReady;
  logic        rfWE;
  logic [4:0]  rfAW;
  logic [31:0] rfWD;
  logic [31:0] busyMask;
  logic        stallReq;

  modport master (
    output RegWrite, toAW, wbData, auxValid, auxAddr, auxData,
    input  auxReady, rfWE, rfAW, rfWD, busyMask, stallReq
  );

  modport slave (
    input  RegWrite, toAW, wbData, auxValid, auxAddr, auxData,
    output auxReady, rfWE, rfAW, rfWD, busyMask, stallReq
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter: pipeline writeback first, buffered aux results fill idle cycles.
// Optional WBARB_STARVE_EN adds the starvation counter driving stallReq; otherwise stallReq is 0.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic        clkWBArb,
  input logic        rstWBArb,
  wb_arbiter_if.slave wb
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarve
    $error("wb_arbiter: STARVE_MAX must be in 1..15");
  end

  logic [4:0]  addrMem [FIFO_DEPTH];
  logic [31:0] dataMem [FIFO_DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic [AW:0] count;
  logic        fifoEmpty;
  logic        pipeGrant;
  logic        doPush;
  logic        doPop;
  logic [4:0]  headAddr;
  logic [31:0] headData;
  logic [31:0] pendMask;
  logic [AW-1:0] slotOff;

  // The extra wrap bit lets the pointer difference span 0..FIFO_DEPTH.
  assign count     = wrPtr - rdPtr;
  assign fifoEmpty = (count == '0);
  assign headAddr  = addrMem[rdPtr[AW-1:0]];
  assign headData  = dataMem[rdPtr[AW-1:0]];

  assign wb.auxReady = !rstWBArb && (count < (AW+1)'(FIFO_DEPTH));
  assign pipeGrant   = wb.RegWrite && (wb.toAW != 5'd0);
  assign doPush      = wb.auxValid && wb.auxReady;
  assign doPop       = !rstWBArb && !pipeGrant && !fifoEmpty;

  always_ff @(posedge clkWBArb) begin
    if (rstWBArb) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clkWBArb) begin
    if (doPush) begin
      addrMem[wrPtr[AW-1:0]] <= wb.auxAddr;
      dataMem[wrPtr[AW-1:0]] <= wb.auxData;
    end
  end

  always_ff @(posedge clkWBArb) begin
    if (rstWBArb) begin
      wb.rfWE <= 1'b0;
      wb.rfAW <= 5'd0;
      wb.rfWD <= 32'd0;
    end else if (pipeGrant) begin
      wb.rfWE <= 1'b1;
      wb.rfAW <= wb.toAW;
      wb.rfWD <= wb.wbData;
    end else if (doPop) begin
      // Entries for r0 still drain so the FIFO never wedges on them.
      wb.rfWE <= (headAddr != 5'd0);
      wb.rfAW <= headAddr;
      wb.rfWD <= headData;
    end else begin
      wb.rfWE <= 1'b0;
    end
  end

  always_comb begin
    pendMask = '0;
    slotOff  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slotOff = AW'(i) - rdPtr[AW-1:0];
      if ({1'b0, slotOff} < count) pendMask[addrMem[i]] = 1'b1;
    end
    pendMask[0] = 1'b0;
  end

  assign wb.busyMask = pendMask;

`ifdef WBARB_STARVE_EN
  logic [3:0] starveCnt;

  always_ff @(posedge clkWBArb) begin
    if (rstWBArb) begin
      starveCnt <= 4'd0;
    end else if (doPop || fifoEmpty) begin
      starveCnt <= 4'd0;
    end else if (starveCnt != 4'(STARVE_MAX)) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  assign wb.stallReq = (starveCnt == 4'(STARVE_MAX));
`else
  assign wb.stallReq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter (FIFO_DEPTH=2, STARVE_MAX=4).
module tb_wb_arbiter;

  logic clkWBArb = 1'b0;
  logic rstWBArb = 1'b1;
  bit   done     = 1'b0;

  always #5 clkWBArb = ~clkWBArb;

  wb_arbiter_if bus ();

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clkWBArb(clkWBArb),
    .rstWBArb(rstWBArb),
    .wb      (bus)
  );

`ifdef WBARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  typedef struct {
    logic [4:0]  aw;
    logic [31:0] wd;
  } wrT;

  typedef struct {
    logic [31:0] busy;
    logic        ready;
    logic        stall;
    logic        we;
    logic        chkRegs;
  } stT;

  wrT wrQ [$];
  stT stQ [$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clkWBArb);
    #1;
  endtask

  task automatic expW(input logic [4:0] a, input logic [31:0] d);
    wrT w;
    w.aw = a;
    w.wd = d;
    wrQ.push_back(w);
  endtask

  task automatic expS(input logic [31:0] busy, input logic ready, input logic stall,
                      input logic we, input logic chkRegs);
    stT s;
    s.busy    = busy;
    s.ready   = ready;
    s.stall   = stall & StarveOn;
    s.we      = we;
    s.chkRegs = chkRegs;
    stQ.push_back(s);
  endtask

  task automatic drivePipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.RegWrite = we;
    bus.toAW     = a;
    bus.wbData   = d;
  endtask

  task automatic driveAux(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.auxValid = v;
    bus.auxAddr  = a;
    bus.auxData  = d;
  endtask

  initial begin : stimulus
    drivePipe(1'b0, 5'd0, 32'd0);
    driveAux(1'b0, 5'd0, 32'd0);
    rstWBArb = 1'b1;
    tick(); tick();
    expS(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rstWBArb = 1'b0;

    // single pipeline write
    drivePipe(1'b1, 5'd5, 32'hDEADBEEF); expW(5'd5, 32'hDEADBEEF);
    tick(); drivePipe(1'b0, 5'd0, 32'd0); expS(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // single aux write through an idle port
    driveAux(1'b1, 5'd7, 32'h1234);
    tick(); driveAux(1'b0, 5'd0, 32'd0); expS(32'h80, 1'b1, 1'b0, 1'b0, 1'b0); expW(5'd7, 32'h1234);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // continuous pipeline writes starve two buffered aux results
    drivePipe(1'b1, 5'd3, 32'hA0000003); driveAux(1'b1, 5'd10, 32'h1111); expW(5'd3, 32'hA0000003);
    tick(); driveAux(1'b1, 5'd11, 32'h2222); expW(5'd3, 32'hA0000003); expS(32'h400, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); driveAux(1'b0, 5'd0, 32'd0);     expW(5'd3, 32'hA0000003); expS(32'hC00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); expW(5'd3, 32'hA0000003); expS(32'hC00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); expW(5'd3, 32'hA0000003); expS(32'hC00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'hC00, 1'b0, 1'b1, 1'b1, 1'b0);
    drivePipe(1'b0, 5'd0, 32'd0); expW(5'd10, 32'h1111); expW(5'd11, 32'h2222);
    tick(); expS(32'h800, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // r0 on both paths: nothing is ever written
    driveAux(1'b1, 5'd0, 32'h5555); drivePipe(1'b1, 5'd0, 32'h9999);
    tick(); driveAux(1'b0, 5'd0, 32'd0); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); drivePipe(1'b0, 5'd0, 32'd0); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // full FIFO: push offered on the pop cycle is refused, accepted one cycle later
    drivePipe(1'b1, 5'd4, 32'h44); driveAux(1'b1, 5'd20, 32'hA1); expW(5'd4, 32'h44);
    tick(); driveAux(1'b1, 5'd21, 32'hA2); expW(5'd4, 32'h44); expS(32'h100000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); drivePipe(1'b0, 5'd0, 32'd0); driveAux(1'b1, 5'd22, 32'hA3); expW(5'd20, 32'hA1);
    expS(32'h300000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); expW(5'd21, 32'hA2); expS(32'h200000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); driveAux(1'b0, 5'd0, 32'd0); expW(5'd22, 32'hA3); expS(32'h400000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset with two entries buffered discards them
    drivePipe(1'b1, 5'd6, 32'h66); driveAux(1'b1, 5'd12, 32'hB1); expW(5'd6, 32'h66);
    tick(); driveAux(1'b1, 5'd13, 32'hB2); expW(5'd6, 32'h66); expS(32'h1000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); driveAux(1'b0, 5'd0, 32'd0); rstWBArb = 1'b1; expS(32'h3000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); rstWBArb = 1'b0; drivePipe(1'b0, 5'd0, 32'd0); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); expS(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    done = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int cyc;
    stT s;
    wrT w;
    cyc = 0;
    forever begin
      @(negedge clkWBArb);
      cyc++;
      if (stQ.size() > 0) begin
        s = stQ.pop_front();
        chk("busyMask", bus.busyMask, s.busy);
        chk("auxReady", {31'd0, bus.auxReady}, {31'd0, s.ready});
        chk("stallReq", {31'd0, bus.stallReq}, {31'd0, s.stall});
        chk("rfWE",     {31'd0, bus.rfWE},     {31'd0, s.we});
        if (s.chkRegs) begin
          chk("rfAW_reset", {27'd0, bus.rfAW}, 32'd0);
          chk("rfWD_reset", bus.rfWD, 32'd0);
        end
      end
      if (bus.rfWE === 1'b1) begin
        if (wrQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rfAW=%0d rfWD=%h expected no write at %0t",
                   bus.rfAW, bus.rfWD, $time);
        end else begin
          w = wrQ.pop_front();
          chk("write_addr", {27'd0, bus.rfAW}, {27'd0, w.aw});
          chk("write_data", bus.rfWD, w.wd);
        end
      end
      if (done && stQ.size() == 0) begin
        chk("pending_writes", wrQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (cyc > 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single register-file write port between the MEM/WB writeback path and a multi-cycle auxiliary unit (multiply/divide) that returns results out of pipeline order. It sits at the end of the pipeline, after the MemtoReg writeback mux, and drives the register-file write port. Auxiliary results are buffered in a small FIFO and written whenever the pipeline leaves the port idle. The block exports a pending-write mask and a stall request for the hazard unit.

## Interface
- FIFO_DEPTH, 2: auxiliary result buffer depth; power of two, ≥2.
- STARVE_MAX, 4: consecutive denied cycles before stallReq asserts; 1..15.

- clkWBArb  in  1  rising-edge clock.
- rstWBArb  in  1  reset, synchronous, active-high.
- RegWrite  in  1  pipeline writeback enable (from MEM/WB).
- toAW  in  5  pipeline destination register.
- wbData  in  32  pipeline writeback data (MemtoReg mux output).
- auxValid  in  1  auxiliary result offered.
- auxAddr  in  5  auxiliary destination register.
- auxData  in  32  auxiliary result.
- auxReady  out  1  FIFO can accept; transfer when auxValid && auxReady at the clock edge.
- rfWE  out  1  registered register-file write enable.
- rfAW  out  5  registered write address.
- rfWD  out  32  registered write data.
- busyMask  out  32  bit i set while any valid FIFO entry targets register i; bit 0 always 0.
- stallReq  out  1  requests a pipeline bubble so the FIFO can drain.

## Operation
- Pipeline grant: if RegWrite=1 and toAW≠0, register rfWE=1, rfAW=toAW, rfWD=wbData. The pipeline is never refused.
- Aux grant: if no pipeline grant and the FIFO is non-empty, pop the head. Register rfWE=(head addr≠0), rfAW=head addr, rfWD=head data.
- Idle: rfWE=0. rfAW/rfWD hold their previous values.
- A pipeline write to register 0 is dropped and counts as no pipeline grant, so the aux path may use that cycle.
- An aux entry addressed to register 0 is accepted and popped normally, but is never written.
- FIFO: circular read and write pointers with log2(FIFO_DEPTH)+1-bit wrap, plus an occupancy count 0..FIFO_DEPTH.
  - auxReady = !rstWBArb && count<FIFO_DEPTH. It does not depend on a same-cycle pop.
- Simultaneous push and pop: both occur; count is unchanged. A push into an empty FIFO is not bypassed.
- busyMask is combinational from valid entries only. The hazard unit uses it to block RAW and WAW hazards on pending registers; the arbiter performs no address-ordering checks.
- Starvation counter: increments each cycle the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
- stallReq = (counter == STARVE_MAX). It is registered and stays high until the cycle after a pop.

## Timing
- Reset values: rfWE=0, rfAW=0, rfWD=0, FIFO empty, busyMask=0, stallReq=0, counter=0, auxReady=0 while reset is high.
- Reset mid-operation discards all FIFO contents. No write is issued in the reset cycle.
- Pipeline write latency: inputs sampled at edge N; rfWE/rfAW/rfWD valid after edge N.
- Aux write latency: accepted at edge N; earliest write registered at edge N+1.
- busyMask bit sets after the push edge and clears after the pop edge.
- When full, auxReady=0 in the same cycle. It rises the cycle after a pop.
- With STARVE_MAX=k and continuous pipeline writes, stallReq rises after k denied edges.

## Configuration
- WBARB_STARVE_EN defined: starvation counter and stallReq logic present as described.
- WBARB_STARVE_EN undefined: counter omitted and stallReq tied to 0. FIFO drain then depends solely on natural pipeline bubbles.

## Test plan
- Reset, then RegWrite=1, toAW=5, wbData=0xDEADBEEF for one cycle -> next cycle rfWE=1, rfAW=5, rfWD=0xDEADBEEF; then rfWE=0.
- RegWrite=0; push aux (addr 7, data 0x1234) -> busyMask=0x80 after the push edge; rfWE=1, rfAW=7, rfWD=0x1234 after the following edge; busyMask=0.
- Hold RegWrite=1, toAW=3; push 2 aux results -> auxReady=0 with count=2. With STARVE_MAX=4, stallReq=1 after 4 edges. Drop RegWrite -> two aux writes in order, then stallReq=0.
- Push aux to register 0 plus pipeline RegWrite=1, toAW=0 -> no rfWE ever asserts; FIFO returns to empty and auxReady=1.
- FIFO full; on the same cycle pop (RegWrite=0) and offer a push -> push refused (auxReady=0); accepted on the next cycle; write order preserved.
- Assert rstWBArb while 2 entries are buffered -> busyMask=0, rfWE=0, stallReq=0, and no buffered write appears after reset.
